peak_meter_encoder: RTL and testbench

PEAK_METER_ENCODER -- requirements
Module: peak_meter_encoder

---
 rtl/peak_meter_pkg.sv | 22 ++
 rtl/level_to_code.sv | 27 ++
 rtl/peak_meter_encoder.sv | 112 +++++++++++
 tb/tb_peak_meter_encoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_meter_pkg.sv
// Shared types and constants for the peak meter: state encoding, level range,
// code widths and the sample-to-level rounding.
package peak_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    localparam int LEVEL_MAX = 16;
    localparam int CODE_W    = 6;
    localparam int LEVEL_W   = 5;
    localparam int SAMPLE_W  = 8;
    localparam int CNT_W     = 16;

    // Round-to-nearest sixteenth of full scale; the 9-bit sum keeps 255+8 intact.
    function automatic logic [LEVEL_W-1:0] target_level(input logic [SAMPLE_W-1:0] sample);
        return LEVEL_W'(({1'b0, sample} + 9'd8) >> 4);
    endfunction

endpackage

// File: rtl/level_to_code.sv
// Combinational level-to-segment-code converter: group in the top two bits,
// LSB-aligned thermometer of the remainder in the low four bits.
module level_to_code
    import peak_meter_pkg::*;
(
    input  logic [LEVEL_W-1:0] level,
    output logic [CODE_W-1:0]  code
);

    logic [1:0] grp;
    logic [2:0] ones;
    logic [3:0] thermo;

    // Level 16 is the only value with bit 4 set; it folds into group 3 with four ones.
    assign grp  = level[4] ? 2'd3 : level[3:2];
    assign ones = level[4] ? 3'd4 : {1'b0, level[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_thermo
            assign thermo[gi] = (ones > 3'(gi));
        end
    endgenerate

    assign code = {grp, thermo};

endmodule

// File: rtl/peak_meter_encoder.sv
// Peak-hold level meter: captures the rounded sample peak, holds it for
// HOLD_CYCLES, then decays one step every DECAY_CYCLES; outputs are registered.
module peak_meter_encoder
    import peak_meter_pkg::*;
#(
    parameter int HOLD_CYCLES  = 1000,
    parameter int DECAY_CYCLES = 100
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLEAR,
    input  logic                SAMPLE_VALID,
    input  logic [SAMPLE_W-1:0] SAMPLE,
    output logic [CODE_W-1:0]   OUT,
    output logic [LEVEL_W-1:0]  LEVEL,
    output logic                HOLDING
);

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DECAY_LOAD = CNT_W'(DECAY_CYCLES - 1);

    state_t               state_reg, state_next;
    logic [LEVEL_W-1:0]   level_reg, level_next;
    logic [CNT_W-1:0]     hold_cnt_reg, hold_cnt_next;
    logic [CNT_W-1:0]     decay_cnt_reg, decay_cnt_next;
    logic [CODE_W-1:0]    out_reg, code_next;
    logic                 holding_reg;

    logic [LEVEL_W-1:0]   target;
    logic                 take_sample;

    assign target = target_level(SAMPLE);
    // A higher peak always loads; an equal non-zero peak only refreshes the hold.
    assign take_sample = SAMPLE_VALID &&
                         ((target > level_reg) || ((target == level_reg) && (level_reg != '0)));

    always_comb begin
        state_next     = state_reg;
        level_next     = level_reg;
        hold_cnt_next  = hold_cnt_reg;
        decay_cnt_next = decay_cnt_reg;

        if (CLEAR) begin
            state_next     = ST_IDLE;
            level_next     = '0;
            hold_cnt_next  = '0;
            decay_cnt_next = '0;
        end else if (take_sample) begin
            state_next     = ST_HOLD;
            level_next     = target;
            hold_cnt_next  = HOLD_LOAD;
            decay_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (hold_cnt_reg == '0) begin
                        state_next     = ST_DECAY;
                        decay_cnt_next = DECAY_LOAD;
                    end else begin
                        hold_cnt_next = hold_cnt_reg - 1'b1;
                    end
                end
                ST_DECAY: begin
                    if (decay_cnt_reg != '0) begin
                        decay_cnt_next = decay_cnt_reg - 1'b1;
                    end else if (level_reg <= 5'd1) begin
                        state_next     = ST_IDLE;
                        level_next     = '0;
                        decay_cnt_next = '0;
                    end else begin
                        level_next     = level_reg - 1'b1;
                        decay_cnt_next = DECAY_LOAD;
                    end
                end
                default: begin
                    state_next     = ST_IDLE;
                    level_next     = '0;
                    hold_cnt_next  = '0;
                    decay_cnt_next = '0;
                end
            endcase
        end
    end

    level_to_code u_level_to_code (
        .level (level_next),
        .code  (code_next)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            level_reg     <= '0;
            hold_cnt_reg  <= '0;
            decay_cnt_reg <= '0;
            out_reg       <= '0;
            holding_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            level_reg     <= level_next;
            hold_cnt_reg  <= hold_cnt_next;
            decay_cnt_reg <= decay_cnt_next;
            out_reg       <= code_next;
            holding_reg   <= (state_next == ST_HOLD);
        end
    end

    assign OUT     = out_reg;
    assign LEVEL   = level_reg;
    assign HOLDING = holding_reg;

endmodule

// File: tb/tb_peak_meter_encoder.sv
// Directed self-checking bench for peak_meter_encoder with HOLD_CYCLES=4,
// DECAY_CYCLES=2; one line printed per driven sample.
module tb_peak_meter_encoder;

    localparam int HOLD  = 4;
    localparam int DECAY = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CLEAR;
    logic       SAMPLE_VALID;
    logic [7:0] SAMPLE;
    logic [5:0] OUT;
    logic [4:0] LEVEL;
    logic       HOLDING;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    peak_meter_encoder #(
        .HOLD_CYCLES  (HOLD),
        .DECAY_CYCLES (DECAY)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .CLEAR        (CLEAR),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE       (SAMPLE),
        .OUT          (OUT),
        .LEVEL        (LEVEL),
        .HOLDING      (HOLDING)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_sample(input logic [7:0] s);
        SAMPLE_VALID = 1'b1;
        SAMPLE       = s;
        tick(1);
        SAMPLE_VALID = 1'b0;
        SAMPLE       = 8'd0;
        $display("sample %0d -> LEVEL=%0d OUT=%b HOLDING=%0b", s, LEVEL, OUT, HOLDING);
    endtask

    task automatic do_clear();
        CLEAR = 1'b1;
        tick(1);
        CLEAR = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; CLEAR = 1'b0; SAMPLE_VALID = 1'b0; SAMPLE = 8'd0;
        tick(3);
        checks++;
        if (OUT !== 6'b000000 || LEVEL !== 5'd0 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL reset_state OUT=%b LEVEL=%0d HOLDING=%b want 000000/0/0", OUT, LEVEL, HOLDING);
        end
        RST = 1'b0;
        tick(5);
        checks++;
        if (OUT !== 6'b000000 || LEVEL !== 5'd0 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle OUT=%b LEVEL=%0d HOLDING=%b want 000000/0/0", OUT, LEVEL, HOLDING);
        end
        drive_sample(8'd0);
        checks++;
        if (LEVEL !== 5'd0 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL zero_sample_ignored LEVEL=%0d HOLDING=%b want 0/0", LEVEL, HOLDING);
        end
    endtask

    task automatic test_hold_decay();
        do_clear();
        drive_sample(8'd200);                       // edge 0
        checks++;
        if (OUT !== 6'b110001 || LEVEL !== 5'd13 || HOLDING !== 1'b1) begin
            failures++;
            $display("FAIL peak_load OUT=%b LEVEL=%0d HOLDING=%b want 110001/13/1", OUT, LEVEL, HOLDING);
        end
        tick(3);                                    // edge 3: last HOLD cycle
        checks++;
        if (HOLDING !== 1'b1 || LEVEL !== 5'd13) begin
            failures++;
            $display("FAIL hold_edge3 HOLDING=%b LEVEL=%0d want 1/13", HOLDING, LEVEL);
        end
        tick(1);                                    // edge 4: DECAY
        checks++;
        if (HOLDING !== 1'b0 || LEVEL !== 5'd13) begin
            failures++;
            $display("FAIL decay_entry HOLDING=%b LEVEL=%0d want 0/13", HOLDING, LEVEL);
        end
        tick(1);                                    // edge 5
        checks++;
        if (LEVEL !== 5'd13) begin
            failures++;
            $display("FAIL pre_first_step LEVEL=%0d want 13", LEVEL);
        end
        tick(1);                                    // edge 6
        checks++;
        if (LEVEL !== 5'd12 || OUT !== 6'b110000) begin
            failures++;
            $display("FAIL first_step LEVEL=%0d OUT=%b want 12/110000", LEVEL, OUT);
        end
        tick(2);                                    // edge 8
        checks++;
        if (LEVEL !== 5'd11) begin
            failures++;
            $display("FAIL second_step LEVEL=%0d want 11", LEVEL);
        end
        tick(21);                                   // edge 29
        checks++;
        if (LEVEL !== 5'd1 || OUT !== 6'b000001) begin
            failures++;
            $display("FAIL last_nonzero LEVEL=%0d OUT=%b want 1/000001", LEVEL, OUT);
        end
        tick(1);                                    // edge 30
        checks++;
        if (LEVEL !== 5'd0 || OUT !== 6'b000000 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL reach_zero LEVEL=%0d OUT=%b HOLDING=%b want 0/000000/0", LEVEL, OUT, HOLDING);
        end
        tick(6);
        checks++;
        if (LEVEL !== 5'd0 || OUT !== 6'b000000) begin
            failures++;
            $display("FAIL no_wrap LEVEL=%0d OUT=%b want 0/000000", LEVEL, OUT);
        end
    endtask

    task automatic test_encoding();
        logic [5:0] exp_code [17];
        logic [7:0] named_s  [4];
        logic [4:0] named_l  [4];
        logic [5:0] named_c  [4];
        exp_code = '{6'b000000, 6'b000001, 6'b000011, 6'b000111,
                     6'b010000, 6'b010001, 6'b010011, 6'b010111,
                     6'b100000, 6'b100001, 6'b100011, 6'b100111,
                     6'b110000, 6'b110001, 6'b110011, 6'b110111,
                     6'b111111};
        named_s = '{8'd8, 8'd72, 8'd120, 8'd255};
        named_l = '{5'd1, 5'd5,  5'd8,   5'd16};
        named_c = '{6'b000001, 6'b010001, 6'b100000, 6'b111111};

        for (int l = 0; l <= 16; l++) begin
            do_clear();
            if (l > 0) drive_sample(8'(16 * l - 8));
            checks++;
            if (LEVEL !== 5'(l) || OUT !== exp_code[l]) begin
                failures++;
                $display("FAIL enc_level_%0d LEVEL=%0d OUT=%b want %0d/%b", l, LEVEL, OUT, l, exp_code[l]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_clear();
            drive_sample(named_s[i]);
            checks++;
            if (LEVEL !== named_l[i] || OUT !== named_c[i]) begin
                failures++;
                $display("FAIL enc_sample_%0d LEVEL=%0d OUT=%b want %0d/%b",
                         named_s[i], LEVEL, OUT, named_l[i], named_c[i]);
            end
        end
        do_clear();
        drive_sample(8'd7);
        checks++;
        if (LEVEL !== 5'd0 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL round_7 LEVEL=%0d HOLDING=%b want 0/0", LEVEL, HOLDING);
        end
        drive_sample(8'd23);
        checks++;
        if (LEVEL !== 5'd1) begin
            failures++;
            $display("FAIL round_23 LEVEL=%0d want 1", LEVEL);
        end
        drive_sample(8'd24);
        checks++;
        if (LEVEL !== 5'd2) begin
            failures++;
            $display("FAIL round_24 LEVEL=%0d want 2", LEVEL);
        end
    endtask

    task automatic test_refresh();
        do_clear();
        drive_sample(8'd100);                       // edge 0, level 6
        drive_sample(8'd40);                        // edge 1, lower: ignored
        checks++;
        if (LEVEL !== 5'd6 || HOLDING !== 1'b1) begin
            failures++;
            $display("FAIL lower_ignored LEVEL=%0d HOLDING=%b want 6/1", LEVEL, HOLDING);
        end
        tick(2);                                    // edge 3: counter at 0
        drive_sample(8'd100);                       // edge 4: refresh instead of expiry
        checks++;
        if (LEVEL !== 5'd6 || HOLDING !== 1'b1) begin
            failures++;
            $display("FAIL refresh_last_hold LEVEL=%0d HOLDING=%b want 6/1", LEVEL, HOLDING);
        end
        tick(3);                                    // edge 7
        checks++;
        if (HOLDING !== 1'b1) begin
            failures++;
            $display("FAIL refresh_still_hold HOLDING=%b want 1", HOLDING);
        end
        tick(1);                                    // edge 8
        checks++;
        if (HOLDING !== 1'b0 || LEVEL !== 5'd6) begin
            failures++;
            $display("FAIL refresh_decay_entry HOLDING=%b LEVEL=%0d want 0/6", HOLDING, LEVEL);
        end
        tick(2);                                    // edge 10
        checks++;
        if (LEVEL !== 5'd5) begin
            failures++;
            $display("FAIL refresh_first_step LEVEL=%0d want 5", LEVEL);
        end
    endtask

    task automatic test_sample_vs_decay();
        do_clear();
        drive_sample(8'd72);                        // edge 0, level 5
        tick(5);                                    // edge 5
        checks++;
        if (LEVEL !== 5'd5 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL pre_collision LEVEL=%0d HOLDING=%b want 5/0", LEVEL, HOLDING);
        end
        drive_sample(8'd255);                       // edge 6: coincides with a decay step
        checks++;
        if (LEVEL !== 5'd16 || HOLDING !== 1'b1 || OUT !== 6'b111111) begin
            failures++;
            $display("FAIL collision LEVEL=%0d HOLDING=%b OUT=%b want 16/1/111111", LEVEL, HOLDING, OUT);
        end
        tick(5);                                    // edge 11
        checks++;
        if (LEVEL !== 5'd16 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL collision_hold_full LEVEL=%0d HOLDING=%b want 16/0", LEVEL, HOLDING);
        end
        tick(1);                                    // edge 12
        checks++;
        if (LEVEL !== 5'd15) begin
            failures++;
            $display("FAIL collision_first_step LEVEL=%0d want 15", LEVEL);
        end
    endtask

    task automatic test_clear_reset();
        do_clear();
        drive_sample(8'd136);                       // level 9
        tick(5);
        checks++;
        if (LEVEL !== 5'd9 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL mid_decay_setup LEVEL=%0d HOLDING=%b want 9/0", LEVEL, HOLDING);
        end
        CLEAR = 1'b1; SAMPLE_VALID = 1'b1; SAMPLE = 8'd255;
        tick(1);
        CLEAR = 1'b0; SAMPLE_VALID = 1'b0; SAMPLE = 8'd0;
        checks++;
        if (LEVEL !== 5'd0 || OUT !== 6'b000000 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL clear_over_sample LEVEL=%0d OUT=%b HOLDING=%b want 0/000000/0", LEVEL, OUT, HOLDING);
        end
        tick(4);
        checks++;
        if (LEVEL !== 5'd0 || OUT !== 6'b000000) begin
            failures++;
            $display("FAIL clear_stays_zero LEVEL=%0d OUT=%b want 0/000000", LEVEL, OUT);
        end
        drive_sample(8'd136);
        tick(5);
        RST = 1'b1; CLEAR = 1'b1; SAMPLE_VALID = 1'b1; SAMPLE = 8'd255;
        tick(1);
        checks++;
        if (LEVEL !== 5'd0 || OUT !== 6'b000000 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL reset_over_sample LEVEL=%0d OUT=%b HOLDING=%b want 0/000000/0", LEVEL, OUT, HOLDING);
        end
        RST = 1'b0; CLEAR = 1'b0; SAMPLE_VALID = 1'b0; SAMPLE = 8'd0;
        tick(10);
        checks++;
        if (LEVEL !== 5'd0 || HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_residual LEVEL=%0d HOLDING=%b want 0/0", LEVEL, HOLDING);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        drive_sample(8'd8);
        drive_sample(8'd40);
        checks++;
        if (LEVEL !== 5'd3 || OUT !== 6'b000111) begin
            failures++;
            $display("FAIL b2b_step2 LEVEL=%0d OUT=%b want 3/000111", LEVEL, OUT);
        end
        drive_sample(8'd72);
        drive_sample(8'd40);
        checks++;
        if (LEVEL !== 5'd5 || HOLDING !== 1'b1) begin
            failures++;
            $display("FAIL b2b_lower LEVEL=%0d HOLDING=%b want 5/1", LEVEL, HOLDING);
        end
        tick(3);
        checks++;
        if (HOLDING !== 1'b0) begin
            failures++;
            $display("FAIL b2b_decay HOLDING=%b want 0", HOLDING);
        end
        drive_sample(8'd72);                        // equal peak during DECAY refreshes
        checks++;
        if (LEVEL !== 5'd5 || HOLDING !== 1'b1) begin
            failures++;
            $display("FAIL b2b_refresh_decay LEVEL=%0d HOLDING=%b want 5/1", LEVEL, HOLDING);
        end
    endtask

    initial begin
        test_reset();
        test_hold_decay();
        test_encoding();
        test_refresh();
        test_sample_vs_decay();
        test_clear_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
